// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and grant encoding for the FIFO write-arbiter controller.
package fifo_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_SIZE_DEF  = 3;
    localparam int DEPTH          = 2 ** ADDR_SIZE_DEF;

    typedef enum logic {
        GRANT_REQ0 = 1'b0,
        GRANT_REQ1 = 1'b1
    } grant_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; last_grant only moves when a grant is accepted.
module rr_arbiter2
    import fifo_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0_valid,
    input  logic req1_valid,
    input  logic accept,
    output logic grant0,
    output logic grant1
);

    grant_e last_grant;
    grant_e last_grant_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GRANT_REQ1;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    // On contention the requester that was not served last wins.
    always_comb begin
        grant0          = 1'b0;
        grant1          = 1'b0;
        last_grant_next = last_grant;
        if (req0_valid && req1_valid) begin
            grant0 = (last_grant == GRANT_REQ1);
            grant1 = (last_grant == GRANT_REQ0);
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
        if (accept) begin
            last_grant_next = grant1 ? GRANT_REQ1 : GRANT_REQ0;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter_ctrl.sv
// Pointer/flag controller for the shared FIFO memory with a two-way write arbiter.
// Optional almost_full output is enabled with FIFO_CTRL_ALMOST_FULL_EN.
module fifo_wr_arbiter_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_SIZE  = ADDR_SIZE_DEF
`ifdef FIFO_CTRL_ALMOST_FULL_EN
    ,
    parameter int AF_THRESHOLD = 6
`endif
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  rd_en,
    output logic                  mem_w_clk_en,
    output logic [ADDR_SIZE-1:0]  mem_w_addr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    output logic [ADDR_SIZE-1:0]  mem_r_addr,
`ifdef FIFO_CTRL_ALMOST_FULL_EN
    output logic                  almost_full,
`endif
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_SIZE:0]    count
);

    localparam logic [ADDR_SIZE:0] PTR_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};

    logic [ADDR_SIZE:0] wr_ptr;
    logic [ADDR_SIZE:0] rd_ptr;
    logic               grant0;
    logic               grant1;
    logic               push;
    logic               pop;

    rr_arbiter2 u_arbiter (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .accept     (push),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    // The extra MSB is the wrap bit: equal pointers mean empty, differing only in it means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_SIZE] != rd_ptr[ADDR_SIZE]) &&
                   (wr_ptr[ADDR_SIZE-1:0] == rd_ptr[ADDR_SIZE-1:0]);
    assign count = wr_ptr - rd_ptr;

`ifdef FIFO_CTRL_ALMOST_FULL_EN
    localparam logic [ADDR_SIZE:0] AF_LEVEL = AF_THRESHOLD[ADDR_SIZE:0];
    assign almost_full = (count >= AF_LEVEL);
`endif

    // Ready is held low during reset so requesters never see an acceptance while pointers are cleared.
    assign req0_ready = grant0 & ~full & ~reset;
    assign req1_ready = grant1 & ~full & ~reset;
    assign push       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign pop        = rd_en & ~empty;

    assign mem_w_clk_en = push;
    assign mem_w_addr   = wr_ptr[ADDR_SIZE-1:0];
    assign mem_w_data   = grant1 ? req1_data : req0_data;
    assign mem_r_addr   = rd_ptr[ADDR_SIZE-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: doc/fifo_wr_arbiter_ctrl.md
Name: fifo_wr_arbiter_ctrl

Overview:
- Single-clock controller for the shared 8-entry FIFO memory.
- Arbitrates two write requesters (round-robin) onto the single memory write port.
- Owns read and write pointers, full and empty flags, and the occupancy count.
- Drives memory write-enable, write address, write data and read address; sits between the requesters and the read-side consumer.

Parameters:
- DATA_WIDTH, 8, width of requester data and memory word.
- ADDR_SIZE, 3, memory address width; depth = 2**ADDR_SIZE.
- AF_THRESHOLD, 6, occupancy at or above which almost_full asserts (only with the optional feature).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  DATA_WIDTH  requester 0 word.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req1_valid  in  1  requester 1 has a word.
- req1_data  in  DATA_WIDTH  requester 1 word.
- req1_ready  out  1  requester 1 word accepted this cycle.
- rd_en  in  1  consumer pops the word currently presented on memory r_data.
- mem_w_clk_en  out  1  memory write enable.
- mem_w_addr  out  ADDR_SIZE  memory write address.
- mem_w_data  out  DATA_WIDTH  memory write data.
- mem_r_addr  out  ADDR_SIZE  memory read address (memory read is combinational).
- full  out  1  occupancy == depth.
- empty  out  1  occupancy == 0.
- count  out  ADDR_SIZE+1  current occupancy, 0..depth.

Behaviour:
- Clock and reset are fixed: one clock, asynchronous active-high reset.
- The memory's reset is active-low. The integrator drives it with ~reset; this block does not drive it.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_SIZE+1 bits, registered.
  - Addresses are the low ADDR_SIZE bits; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (MSBs differ and low bits equal).
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_SIZE+1).
  - All three outputs are derived combinationally from the registered pointers.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, last_grant = 1 (requester 0 wins first).
  - Outputs: empty = 1, full = 0, count = 0, ready = 0, mem_w_clk_en = 0, mem_w_addr = 0, mem_r_addr = 0.
- Arbitration (state = last_grant register, 1 bit):
  - Only one valid: grant that requester.
  - Both valid: grant the requester that is not last_grant.
  - last_grant updates only on an accepted write.
- Handshake:
  - reqN_ready = grantN & ~full. It is combinational and may depend on the valids.
  - Transfer occurs when reqN_valid & reqN_ready.
  - A requester must hold valid and data stable until accepted.
- Write path:
  - On transfer: mem_w_clk_en = 1, mem_w_addr = wr_ptr low bits, mem_w_data = granted data, all combinational in the same cycle.
  - wr_ptr increments at the clock edge. Write-to-visible latency is 1 cycle: empty deasserts the cycle after the write.
- Read path:
  - mem_r_addr = rd_ptr low bits; the head word is always presented.
  - rd_en & ~empty: rd_ptr increments at the edge.
  - rd_en while empty: ignored, no pointer change.
- Boundary conditions:
  - Write while full is blocked even if rd_en is asserted the same cycle; no bypass.
  - Simultaneous read and write when neither full nor empty: both pointers advance, count unchanged.
  - Pointers wrap naturally 7 -> 0, with the wrap bit toggling.
  - Reset asserted mid-operation clears pointers immediately (asynchronously). Contents are discarded.

Optional Feature:
- Macro: FIFO_CTRL_ALMOST_FULL_EN.
- Defined: adds output almost_full (1 bit) = (count >= AF_THRESHOLD), combinational; reset value 0.
- Undefined: no almost_full port; AF_THRESHOLD is unused.

Decomposition:
- Package fifo_ctrl_pkg:
  - default DATA_WIDTH and ADDR_SIZE constants;
  - DEPTH constant;
  - grant encoding constants GRANT_REQ0 = 0, GRANT_REQ1 = 1.
- Sub-module rr_arbiter2:
  - two-request round-robin grant with the last_grant register;
  - inputs: valids, accept strobe;
  - outputs: grant0, grant1.

Test Plan:
- Reset then idle: empty = 1, full = 0, count = 0, ready = 0, mem_w_clk_en = 0; rd_en = 1 leaves rd_ptr = 0.
- req0 only, writes 0xA1..0xA8 on 8 consecutive cycles:
  - each accepted, mem_w_addr 0..7;
  - full = 1, count = 8 after the 8th;
  - 9th attempt gives req0_ready = 0.
- Both requesters valid continuously from reset (req0 = 0x10, req1 = 0x20), with rd_en = 1 each cycle after the first write:
  - grants alternate req0, req1, req0, ...;
  - memory receives 0x10, 0x20, 0x10, ...
- Fill to full, then assert rd_en and req1_valid in the same cycle:
  - read accepted, write blocked, count = 7;
  - next cycle the write is accepted and count returns to 8.
- Fill 3 words, read 3, write 8 more:
  - wrap occurs, addresses go 3..7 then 0..2;
  - full = 1 and mem_r_addr = 3.
- Assert reset mid-stream with count = 5: outputs return immediately to reset values. With FIFO_CTRL_ALMOST_FULL_EN defined, almost_full = 1 at count 6 and 0 at count 5.
